ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage; consumes the ID/EX register outputs and drives the EX/MEM register.
//  Contains the integer ALU, branch/jump resolution and an iterative RV32M multiply/divide unit.
//  Drives hold_n_o low to freeze the upstream pipeline registers while a mul/div iterates.
// PARAMETERS
//  DW       32  datapath width (XLEN); only 32 is supported
//  MD_ITER  32  mul/div iterations, one result bit per cycle
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   asynchronous, active-high reset
//  instr_i          in   32  instruction in EX; 32'h0 is a bubble (ID/EX reset value)
//  data_rs1_i       in   32  rs1 value
//  data_rs2_i       in   32  rs2 value
//  alu_operation_i  in   3   `ALU_* code (ADD,SLL,SLT,SLTU,XOR,SR,OR,AND)
//  alu_op_num1_i    in   32  ALU operand 1
//  alu_op_num2_i    in   32  ALU operand 2
//  jmp_op_num1_i    in   32  jump target base
//  jmp_op_num2_i    in   32  jump target offset
//  jmp_flag_i       in   1   instruction is JAL/JALR/branch
//  load_code_i      in   `BUS_L_CODE  load type, passed through
//  store_code_i     in   `BUS_S_CODE  store type, passed through
//  rd_data_o        out  32  writeback value
//  rd_addr_o        out  5   instr_i[11:7]
//  rd_wen_o         out  1   register write enable
//  mem_addr_o       out  32  load/store address (ALU ADD result)
//  mem_wdata_o      out  32  store data (data_rs2_i)
//  load_code_o      out  `BUS_L_CODE  = load_code_i
//  store_code_o     out  `BUS_S_CODE  = store_code_i
//  jmp_en_o         out  1   redirect the PC this cycle
//  jmp_addr_o       out  32  redirect target
//  hold_n_o         out  1   0 = freeze PC/IF-ID/ID-EX and do not capture EX/MEM
// BEHAVIOUR
//  - Outputs are combinational from inputs and mul/div state; only the mul/div state is registered.
//  - After reset with bubble input: all outputs 0, except hold_n_o=1.
//  - ALU: SUB when ADD and instr_i[30]=1 on R-type; SRA when SR and instr_i[30]=1, else SRL.
//    Shift amount is op2[4:0]. SLT is signed, SLTU is unsigned. Results are mod 2^32.
//  - rd_wen_o=1 iff not a bubble, opcode is not STORE/BRANCH, and rd!=0.
//  - Jumps: jmp_addr_o = jmp_op_num1_i + jmp_op_num2_i; bit0 cleared for JALR.
//    JAL/JALR: jmp_en_o = jmp_flag_i. Branch: jmp_flag_i AND funct3 compare of rs1 vs rs2
//    (BEQ,BNE,BLT,BGE,BLTU,BGEU). rd_data_o = alu result (PC+4 is supplied by ID).
//  - Mul/div: opcode 0110011 with funct7 0000001. FSM states IDLE -> BUSY -> DONE -> IDLE.
//    IDLE, mul/div seen: hold_n_o=0 in the same cycle; latch |operands|, signs, funct3;
//      count=0; go to BUSY.
//    BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; hold_n_o=0;
//      after count=MD_ITER-1, go to DONE.
//    DONE: rd_data_o = sign-corrected result; hold_n_o=1 so EX/MEM captures it; go to IDLE.
//    Net effect: the EX/MEM capture is delayed by 33 cycles (hold_n_o low for 33 cycles).
//  - MUL returns the low 32 bits. MULH/MULHSU/MULHU return the high 32 bits of the signed,
//    signed x unsigned, and unsigned product respectively.
//  - Divide by zero: DIV/DIVU = 32'hFFFFFFFF; REM/REMU = dividend. No stall: result in the IDLE cycle.
//  - Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0. No stall.
//  - Mul/div never asserts jmp_en_o. The FSM ignores instr_i changes while in BUSY (inputs are held).
//  - rst asserted mid-operation: FSM -> IDLE, count=0, partial result discarded, hold_n_o=1.
// CONFIGURATION
//  EX_MULDIV_EN defined: mul/div unit and FSM are present as described above.
//  EX_MULDIV_EN undefined: no FSM or registers. Mul/div encodings give rd_data_o=0 with rd_wen_o=0.
//    hold_n_o is tied to 1.
// STRUCTURE
//  define.v (shared) holds:
//    `ALU_* codes, branch funct3 codes, mul/div funct3 codes
//    `MD_IDLE/`MD_BUSY/`MD_DONE state encodings
//    opcode constants and `ZERO_WORD
//  Sub-module ex_muldiv: FSM, 6-bit counter, operand/accumulator registers, hold request.
//  ex_stage holds the ALU, branch compare and output muxing.
// TESTING
//  1. ADD 7+(-3); SRA 0x80000000>>4 -> rd_data_o=4, then 0xF8000000; hold_n_o=1 on both.
//  2. BLT rs1=-1, rs2=1, target 0x100+0x20 -> jmp_en_o=1, jmp_addr_o=0x120;
//     same with BLTU -> jmp_en_o=0.
//  3. MUL 0xFFFFFFFF x 3 -> hold_n_o=0 for 33 cycles, then rd_data_o=0xFFFFFFFD;
//     MULHU of the same operands -> 2.
//  4. DIV 7/0 -> 0xFFFFFFFF with no stall; REM 0x80000000 % -1 -> 0 with no stall;
//     DIV -7/2 -> -3 after 33 cycles.
//  5. rst pulse at BUSY count 10 -> hold_n_o=1 immediately; the next MUL 5x6 -> 30 with full latency.
//  6. Build without EX_MULDIV_EN: MUL -> rd_wen_o=0, hold_n_o stays 1.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared constants and types for the execute stage.
// EX_MULDIV_EN enables the iterative RV32M unit.
package ex_stage_pkg;

  localparam int DW      = 32;
  localparam int MD_ITER = 32;
  localparam int LCODE_W = 3;
  localparam int SCODE_W = 2;

  localparam logic [DW-1:0] ZERO_WORD = '0;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SLL  = 3'd1;
  localparam logic [2:0] ALU_SLT  = 3'd2;
  localparam logic [2:0] ALU_SLTU = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SR   = 3'd5;
  localparam logic [2:0] ALU_OR   = 3'd6;
  localparam logic [2:0] ALU_AND  = 3'd7;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BLTU = 3'd6;
  localparam logic [2:0] BR_BGEU = 3'd7;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic [DW-1:0] neg_if(
    input logic          n,
    input logic [DW-1:0] v
  );
    return n ? ZERO_WORD - v : v;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage.
// The slave side is the stage itself.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [DW-1:0]      instr_i;
  logic [DW-1:0]      data_rs1_i;
  logic [DW-1:0]      data_rs2_i;
  logic [2:0]         alu_operation_i;
  logic [DW-1:0]      alu_op_num1_i;
  logic [DW-1:0]      alu_op_num2_i;
  logic [DW-1:0]      jmp_op_num1_i;
  logic [DW-1:0]      jmp_op_num2_i;
  logic               jmp_flag_i;
  logic [LCODE_W-1:0] load_code_i;
  logic [SCODE_W-1:0] store_code_i;

  logic [DW-1:0]      rd_data_o;
  logic [4:0]         rd_addr_o;
  logic               rd_wen_o;
  logic [DW-1:0]      mem_addr_o;
  logic [DW-1:0]      mem_wdata_o;
  logic [LCODE_W-1:0] load_code_o;
  logic [SCODE_W-1:0] store_code_o;
  logic               jmp_en_o;
  logic [DW-1:0]      jmp_addr_o;
  logic               hold_n_o;

  modport master (
    output instr_i, data_rs1_i, data_rs2_i,
    output alu_operation_i, alu_op_num1_i, alu_op_num2_i,
    output jmp_op_num1_i, jmp_op_num2_i, jmp_flag_i,
    output load_code_i, store_code_i,
    input  rd_data_o, rd_addr_o, rd_wen_o,
    input  mem_addr_o, mem_wdata_o,
    input  load_code_o, store_code_o,
    input  jmp_en_o, jmp_addr_o, hold_n_o
  );

  modport slave (
    input  instr_i, data_rs1_i, data_rs2_i,
    input  alu_operation_i, alu_op_num1_i, alu_op_num2_i,
    input  jmp_op_num1_i, jmp_op_num2_i, jmp_flag_i,
    input  load_code_i, store_code_i,
    output rd_data_o, rd_addr_o, rd_wen_o,
    output mem_addr_o, mem_wdata_o,
    output load_code_o, store_code_o,
    output jmp_en_o, jmp_addr_o, hold_n_o
  );

endinterface

// File: rtl/ex_stage_muldiv.sv
// Iterative RV32M unit (ex_muldiv), built only when EX_MULDIV_EN is defined.
// Works on magnitudes, one result bit per cycle, sign fixed up in DONE.
`ifdef EX_MULDIV_EN
module ex_muldiv
  import ex_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [2:0]    funct3_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          hold_n_o,
  output logic [DW-1:0] result_o
);

  md_state_e       state_q;
  logic [5:0]      cnt_q;
  logic [63:0]     acc_q;
  logic [63:0]     acc_d;
  logic [DW-1:0]   opb_q;
  logic [2:0]      f3_q;
  logic            neg_q;
  logic            rneg_q;

  logic            sgn_a;
  logic            sgn_b;
  logic            sa;
  logic            sb;
  logic [DW-1:0]   abs_a;
  logic [DW-1:0]   abs_b;
  logic            div0;
  logic            ovf;
  logic            fast;
  logic [DW-1:0]   fast_res;

  assign sgn_a = (funct3_i == MD_MULH) | (funct3_i == MD_MULHSU)
               | (funct3_i == MD_DIV)  | (funct3_i == MD_REM);
  assign sgn_b = (funct3_i == MD_MULH) | (funct3_i == MD_DIV)
               | (funct3_i == MD_REM);
  assign sa    = sgn_a & a_i[DW-1];
  assign sb    = sgn_b & b_i[DW-1];
  assign abs_a = neg_if(sa, a_i);
  assign abs_b = neg_if(sb, b_i);

  // Zero divisor and signed overflow finish without iterating
  assign div0 = funct3_i[2] & (b_i == ZERO_WORD);
  assign ovf  = funct3_i[2] & ~funct3_i[0]
              & (a_i == 32'h8000_0000) & (b_i == 32'hFFFF_FFFF);
  assign fast = div0 | ovf;

  always_comb begin
    fast_res = ZERO_WORD;
    if (div0)
      fast_res = funct3_i[1] ? a_i : 32'hFFFF_FFFF;
    else
      fast_res = funct3_i[1] ? ZERO_WORD : 32'h8000_0000;
  end

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [63:0] mul_nxt;
  logic [63:0] div_nxt;

  assign sum     = {1'b0, acc_q[63:32]}
                 + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_nxt = {sum, acc_q[31:1]};
  assign rem_sh  = {acc_q[63:32], acc_q[31]};
  assign diff    = rem_sh - {1'b0, opb_q};
  assign div_nxt = diff[32]
                 ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                 : {diff[31:0], acc_q[30:0], 1'b1};
  assign acc_d   = f3_q[2] ? div_nxt : mul_nxt;

  logic [63:0]   prod;
  logic [DW-1:0] mul_res;
  logic [DW-1:0] div_res;

  assign prod    = neg_q ? 64'd0 - acc_q : acc_q;
  assign mul_res = (f3_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
  assign div_res = f3_q[1] ? neg_if(rneg_q, acc_q[63:32])
                           : neg_if(neg_q, acc_q[31:0]);

  always_comb begin
    hold_n_o = 1'b1;
    result_o = ZERO_WORD;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i && fast) result_o = fast_res;
        else if (start_i)    hold_n_o = 1'b0;
      end
      MD_BUSY: hold_n_o = 1'b0;
      MD_DONE: result_o = f3_q[2] ? div_res : mul_res;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (start_i && !fast) begin
            acc_q   <= funct3_i[2] ? {32'd0, abs_a} : {32'd0, abs_b};
            opb_q   <= funct3_i[2] ? abs_b : abs_a;
            f3_q    <= funct3_i;
            neg_q   <= sa ^ sb;
            rneg_q  <= sa;
            cnt_q   <= '0;
            state_q <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(MD_ITER - 1)) state_q <= MD_DONE;
        end
        MD_DONE: state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump resolution, optional mul/div.
// Define EX_MULDIV_EN to include the iterative RV32M unit.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave io
);

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [4:0]    rd;
  logic          bubble;
  logic          is_md;
  logic          is_jal;
  logic          is_jalr;
  logic          is_br;

  assign opcode  = io.instr_i[6:0];
  assign funct3  = io.instr_i[14:12];
  assign funct7  = io.instr_i[31:25];
  assign rd      = io.instr_i[11:7];
  assign bubble  = (io.instr_i == ZERO_WORD);
  assign is_md   = (opcode == OPC_OP) && (funct7 == F7_MULDIV);
  assign is_jal  = (opcode == OPC_JAL);
  assign is_jalr = (opcode == OPC_JALR);
  assign is_br   = (opcode == OPC_BRANCH);

  logic [DW-1:0] op1;
  logic [DW-1:0] op2;
  logic [4:0]    shamt;
  logic [DW-1:0] add_res;
  logic [DW-1:0] sra_res;
  logic [DW-1:0] alu_res;

  assign op1     = io.alu_op_num1_i;
  assign op2     = io.alu_op_num2_i;
  assign shamt   = op2[4:0];
  assign add_res = op1 + op2;
  assign sra_res = $signed(op1) >>> shamt;

  always_comb begin
    alu_res = ZERO_WORD;
    unique case (io.alu_operation_i)
      ALU_ADD: begin
        // Only R-type uses bit 30 as SUB; in ADDI it is immediate
        if (opcode == OPC_OP && io.instr_i[30]) alu_res = op1 - op2;
        else                                   alu_res = add_res;
      end
      ALU_SLL:  alu_res = op1 << shamt;
      ALU_SLT:  alu_res = {31'd0, $signed(op1) < $signed(op2)};
      ALU_SLTU: alu_res = {31'd0, op1 < op2};
      ALU_XOR:  alu_res = op1 ^ op2;
      ALU_SR:   alu_res = io.instr_i[30] ? sra_res : op1 >> shamt;
      ALU_OR:   alu_res = op1 | op2;
      ALU_AND:  alu_res = op1 & op2;
    endcase
  end

  logic [DW-1:0] rs1;
  logic [DW-1:0] rs2;
  logic          br_take;

  assign rs1 = io.data_rs1_i;
  assign rs2 = io.data_rs2_i;

  always_comb begin
    br_take = 1'b0;
    unique case (1'b1)
      (funct3 == BR_BEQ):  br_take = (rs1 == rs2);
      (funct3 == BR_BNE):  br_take = (rs1 != rs2);
      (funct3 == BR_BLT):  br_take = ($signed(rs1) < $signed(rs2));
      (funct3 == BR_BGE):  br_take = ($signed(rs1) >= $signed(rs2));
      (funct3 == BR_BLTU): br_take = (rs1 < rs2);
      (funct3 == BR_BGEU): br_take = (rs1 >= rs2);
      default:             br_take = 1'b0;
    endcase
  end

  logic [DW-1:0] jmp_sum;

  assign jmp_sum = io.jmp_op_num1_i + io.jmp_op_num2_i;

  always_comb begin
    io.jmp_en_o = 1'b0;
    if (is_jal || is_jalr) io.jmp_en_o = io.jmp_flag_i;
    else if (is_br)        io.jmp_en_o = io.jmp_flag_i & br_take;
  end

  assign io.jmp_addr_o = is_jalr ? {jmp_sum[DW-1:1], 1'b0} : jmp_sum;

  logic [DW-1:0] md_res;
  logic          md_hold_n;
  logic          wen_base;
  logic          unused_ok;

  assign wen_base = !bubble && (opcode != OPC_STORE)
                 && !is_br && (rd != 5'd0);

`ifdef EX_MULDIV_EN
  ex_muldiv u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (is_md & ~rst),
    .funct3_i (funct3),
    .a_i      (rs1),
    .b_i      (rs2),
    .hold_n_o (md_hold_n),
    .result_o (md_res)
  );

  assign io.rd_wen_o = wen_base;
  assign unused_ok   = ^{io.instr_i[24:15]};
`else
  assign md_res      = ZERO_WORD;
  assign md_hold_n   = 1'b1;
  assign io.rd_wen_o = wen_base && !is_md;
  assign unused_ok   = ^{io.instr_i[24:15], clk, rst};
`endif

  assign io.rd_data_o    = is_md ? md_res : alu_res;
  assign io.rd_addr_o    = rd;
  assign io.hold_n_o     = md_hold_n;
  assign io.mem_addr_o   = add_res;
  assign io.mem_wdata_o  = rs2;
  assign io.load_code_o  = io.load_code_i;
  assign io.store_code_o = io.store_code_i;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table plus scoreboard of expected results.
// Expectations for mul/div encodings follow EX_MULDIV_EN.
module tb_ex_stage;

`ifdef EX_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  aop;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] j1;
    logic [31:0] j2;
    logic        jf;
    logic [31:0] rd;
    logic        wen;
    logic        jen;
    logic [31:0] jaddr;
    int          cyc;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        wen;
    logic        jen;
    logic [31:0] jaddr;
    logic [31:0] maddr;
    logic [4:0]  rdaddr;
    logic [31:0] wdata;
    logic [2:0]  lcode;
    logic [1:0]  scode;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vt[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7,
                                        input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm,
                                        input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] btype(input logic [2:0] f3);
    return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
  endfunction

  function automatic vec_t mk(
    input string n, input logic [31:0] instr,
    input logic [31:0] rs1, input logic [31:0] rs2,
    input logic [2:0] aop, input logic [31:0] op1, input logic [31:0] op2,
    input logic [31:0] j1, input logic [31:0] j2, input logic jf,
    input logic [31:0] rd, input logic wen, input logic jen,
    input logic [31:0] jaddr, input int cyc);
    vec_t v;
    v.name = n; v.instr = instr; v.rs1 = rs1; v.rs2 = rs2;
    v.aop = aop; v.op1 = op1; v.op2 = op2;
    v.j1 = j1; v.j2 = j2; v.jf = jf;
    v.rd = rd; v.wen = wen; v.jen = jen; v.jaddr = jaddr; v.cyc = cyc;
    return v;
  endfunction

  // Multiply/divide vector; operands feed both rs and ALU ports as ID would
  function automatic vec_t mdv(input string n, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input int cyc);
    return mk(n, rtype(7'b0000001, f3, 5'd6), a, b, 3'd0, a, b,
              32'd0, 32'd0, 1'b0, MD ? res : 32'd0, MD, 1'b0, 32'd0,
              MD ? cyc : 0);
  endfunction

  task automatic drive(input vec_t v, input int k, input bit push);
    exp_t e;
    bus.instr_i         = v.instr;
    bus.data_rs1_i      = v.rs1;
    bus.data_rs2_i      = v.rs2;
    bus.alu_operation_i = v.aop;
    bus.alu_op_num1_i   = v.op1;
    bus.alu_op_num2_i   = v.op2;
    bus.jmp_op_num1_i   = v.j1;
    bus.jmp_op_num2_i   = v.j2;
    bus.jmp_flag_i      = v.jf;
    bus.load_code_i     = 3'(k);
    bus.store_code_i    = 2'(k + 1);
    if (push) begin
      e.name   = v.name;
      e.rd     = v.rd;
      e.wen    = v.wen;
      e.jen    = v.jen;
      e.jaddr  = v.jaddr;
      e.maddr  = v.op1 + v.op2;
      e.rdaddr = v.instr[11:7];
      e.wdata  = v.rs2;
      e.lcode  = 3'(k);
      e.scode  = 2'(k + 1);
      e.cyc    = v.cyc;
      sb.push_back(e);
    end
  endtask

  // Waits (bounded) for hold_n_o, then checks the popped expectation
  task automatic measure();
    exp_t e;
    int   n;
    n = 0;
    while (bus.hold_n_o !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      chk({e.name, ".stall"}, 32'(n), 32'(e.cyc));
      chk({e.name, ".rd"}, bus.rd_data_o, e.rd);
      chk({e.name, ".wen"}, 32'(bus.rd_wen_o), 32'(e.wen));
      chk({e.name, ".jen"}, 32'(bus.jmp_en_o), 32'(e.jen));
      chk({e.name, ".jaddr"}, bus.jmp_addr_o, e.jaddr);
      chk({e.name, ".maddr"}, bus.mem_addr_o, e.maddr);
      chk({e.name, ".rdaddr"}, 32'(bus.rd_addr_o), 32'(e.rdaddr));
      chk({e.name, ".wdata"}, bus.mem_wdata_o, e.wdata);
      chk({e.name, ".codes"}, {27'd0, bus.load_code_o, bus.store_code_o},
          {27'd0, e.lcode, e.scode});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt.push_back(mk("add", rtype(7'd0, 3'd0, 5'd5), 0, 0, 3'd0,
      32'd7, 32'hFFFF_FFFD, 0, 0, 0, 32'd4, 1, 0, 0, 0));
    vt.push_back(mk("sra", rtype(7'b0100000, 3'd5, 5'd5), 0, 0, 3'd5,
      32'h8000_0000, 32'd4, 0, 0, 0, 32'hF800_0000, 1, 0, 0, 0));
    vt.push_back(mk("srl", rtype(7'd0, 3'd5, 5'd5), 0, 0, 3'd5,
      32'h8000_0000, 32'd4, 0, 0, 0, 32'h0800_0000, 1, 0, 0, 0));
    vt.push_back(mk("sub", rtype(7'b0100000, 3'd0, 5'd5), 0, 0, 3'd0,
      32'd7, 32'hFFFF_FFFD, 0, 0, 0, 32'd10, 1, 0, 0, 0));
    vt.push_back(mk("addi_rd0", itype(12'h400, 3'd0, 5'd0), 0, 0, 3'd0,
      32'd5, 32'h400, 0, 0, 0, 32'h405, 0, 0, 0, 0));
    vt.push_back(mk("sll", rtype(7'd0, 3'd1, 5'd4), 0, 0, 3'd1,
      32'd1, 32'h3F, 0, 0, 0, 32'h8000_0000, 1, 0, 0, 0));
    vt.push_back(mk("slt", rtype(7'd0, 3'd2, 5'd4), 0, 0, 3'd2,
      32'hFFFF_FFFF, 32'd1, 0, 0, 0, 32'd1, 1, 0, 0, 0));
    vt.push_back(mk("sltu", rtype(7'd0, 3'd3, 5'd4), 0, 0, 3'd3,
      32'hFFFF_FFFF, 32'd1, 0, 0, 0, 32'd0, 1, 0, 0, 0));
    vt.push_back(mk("xor", rtype(7'd0, 3'd4, 5'd4), 0, 0, 3'd4,
      32'hF0F0, 32'hFF00, 0, 0, 0, 32'h0FF0, 1, 0, 0, 0));
    vt.push_back(mk("or", rtype(7'd0, 3'd6, 5'd4), 0, 0, 3'd6,
      32'hF0F0, 32'hFF00, 0, 0, 0, 32'hFFF0, 1, 0, 0, 0));
    vt.push_back(mk("and", rtype(7'd0, 3'd7, 5'd4), 0, 0, 3'd7,
      32'hF0F0, 32'hFF00, 0, 0, 0, 32'hF000, 1, 0, 0, 0));
    vt.push_back(mk("store", {7'd0, 5'd2, 5'd1, 3'd2, 5'd0, 7'b0100011},
      32'd0, 32'hCAFE_BABE, 3'd0, 32'h1000, 32'd8, 0, 0, 0,
      32'h1008, 0, 0, 0, 0));
    vt.push_back(mk("blt", btype(3'd4), 32'hFFFF_FFFF, 32'd1, 3'd0, 0, 0,
      32'h100, 32'h20, 1, 0, 0, 1, 32'h120, 0));
    vt.push_back(mk("bltu", btype(3'd6), 32'hFFFF_FFFF, 32'd1, 3'd0, 0, 0,
      32'h100, 32'h20, 1, 0, 0, 0, 32'h120, 0));
    vt.push_back(mk("beq_noflag", btype(3'd0), 32'd5, 32'd5, 3'd0, 0, 0,
      32'h40, 32'h4, 0, 0, 0, 0, 32'h44, 0));
    vt.push_back(mk("bne", btype(3'd1), 32'd5, 32'd6, 3'd0, 0, 0,
      32'h40, 32'h8, 1, 0, 0, 1, 32'h48, 0));
    vt.push_back(mk("bge", btype(3'd5), 32'hFFFF_FFFF, 32'd1, 3'd0, 0, 0,
      32'h40, 32'h8, 1, 0, 0, 0, 32'h48, 0));
    vt.push_back(mk("bgeu", btype(3'd7), 32'hFFFF_FFFF, 32'd1, 3'd0, 0, 0,
      32'h40, 32'h8, 1, 0, 0, 1, 32'h48, 0));
    vt.push_back(mk("jalr", {12'd0, 5'd1, 3'd0, 5'd1, 7'b1100111}, 0, 0,
      3'd0, 32'h200, 32'd4, 32'h1001, 32'd4, 1, 32'h204, 1, 1,
      32'h1004, 0));
    vt.push_back(mk("jal", {20'd0, 5'd1, 7'b1101111}, 0, 0, 3'd0,
      32'h300, 32'd4, 32'h101, 32'd0, 1, 32'h304, 1, 1, 32'h101, 0));
    vt.push_back(mdv("mul", 3'd0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 33));
    vt.push_back(mdv("mulhu", 3'd3, 32'hFFFF_FFFF, 32'd3, 32'd2, 33));
    vt.push_back(mdv("mulh", 3'd1, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 33));
    vt.push_back(mdv("mulhsu", 3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
      32'hFFFF_FFFE, 33));
    vt.push_back(mdv("div0", 3'd4, 32'd7, 32'd0, 32'hFFFF_FFFF, 0));
    vt.push_back(mdv("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0));
    vt.push_back(mdv("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
      32'h8000_0000, 0));
    vt.push_back(mdv("remu0", 3'd7, 32'd5, 32'd0, 32'd5, 0));
    vt.push_back(mdv("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33));
    vt.push_back(mdv("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33));
    vt.push_back(mdv("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33));
    vt.push_back(mdv("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33));

    drive(mk("bubble", 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
    bus.store_code_i = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset.rd", bus.rd_data_o, 32'd0);
    chk("reset.wen_jen", {30'd0, bus.rd_wen_o, bus.jmp_en_o}, 32'd0);
    chk("reset.addr", bus.mem_addr_o | bus.jmp_addr_o | bus.mem_wdata_o,
        32'd0);
    chk("reset.hold_n", 32'(bus.hold_n_o), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i], i, 1);
      #1;
      measure();
    end

    if (MD) begin
      // Reset in the middle of an iteration, then a clean restart
      drive(mdv("mul_abort", 3'd0, 32'hFFFF_FFFF, 32'd3, 0, 0), 1, 0);
      repeat (11) @(posedge clk);
      #1;
      chk("abort.busy_hold", 32'(bus.hold_n_o), 32'd0);
      rst = 1'b1;
      drive(mdv("mul5x6", 3'd0, 32'd5, 32'd6, 32'd30, 33), 2, 1);
      #1;
      chk("abort.rst_hold", 32'(bus.hold_n_o), 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      measure();
    end

    chk("scoreboard.empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
